game_state_sequencer: RTL
=========================

Name: game_state_sequencer

Overview:
- Per-frame game-logic controller feeding the pad/ball position inputs of the graphics pipeline.
- Detects frame start from the VGA vertical sync and runs a fixed multi-cycle update FSM: pads, then ball, then collisions, then score.
- Publishes all positions atomically in one commit cycle, so the raster never sees a half-updated frame.

Parameters:
- SCREEN_WIDTH, 640, visible width in pixels.
- SCREEN_HEIGHT, 480, visible height in pixels.
- PAD_HEIGHT, 64, pad height in pixels; must be even.
- PAD_WIDTH, 8, pad width in pixels.
- PAD_DISTANCE, 16, gap from the screen edge to the pad's outer edge.
- PAD_SPEED, 4, pad step per frame in pixels.
- BALL_SPEED, 2, ball step per frame per axis in pixels.
- BALL_RADIUS, 4, collision radius in pixels.
- WIN_SCORE, 9, score at which play stops.

Ports:
- clk_vga  in  1  pixel clock; only clock.
- rst  in  1  asynchronous, active-low reset.
- vga_vs  in  1  VGA_VS from video timing, active-low sync pulse.
- btn  in  4  {r_dn, r_up, l_dn, l_up}, level, already synchronised.
- serve  in  1  single-cycle pulse, launches the ball.
- pad_left  out  12  left pad centre y.
- pad_right  out  12  right pad centre y.
- ball_x  out  12  ball centre x.
- ball_y  out  12  ball centre y.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high once either score equals WIN_SCORE.
- busy  out  1  high while the FSM is outside IDLE.

Behaviour:
- Reset values:
  - pad_left = pad_right = SCREEN_HEIGHT/2 (240).
  - ball_x = SCREEN_WIDTH/2 (320), ball_y = 240.
  - Scores 0, game_over 0, busy 0.
  - Direction dx = +1 (right), dy = +1 (down). Launched flag 0.
- Frame start: vs_prev is registered vga_vs. frame_start = vs_prev & ~vga_vs, a falling edge.
  - Accepted only in IDLE.
  - An edge arriving while busy is dropped, not queued.
- FSM: IDLE -> PADS -> BALL -> WALLS -> PADHIT -> SCORE -> COMMIT -> IDLE, one cycle per state.
  - Exit from IDLE requires frame_start.
  - busy = 1 in every state except IDLE.
  - Outputs change only on the COMMIT cycle, 6 cycles after the frame_start cycle.
- Working copies: all arithmetic runs on internal registers. COMMIT copies them to the outputs in the same cycle.
- PADS, per pad:
  - up only: y -= PAD_SPEED. dn only: y += PAD_SPEED. Both or neither: no move.
  - Clamp to [PAD_HEIGHT/2, SCREEN_HEIGHT-1-PAD_HEIGHT/2] = [32, 447]. No wrap below 0.
- BALL:
  - Not launched: ball held at centre and serve is sampled every cycle. serve in any state sets launched, applied at the next BALL state.
  - Launched: x += dx*BALL_SPEED, y += dy*BALL_SPEED, using 13-bit signed intermediates.
- WALLS:
  - y <= BALL_RADIUS: y = BALL_RADIUS, dy = +1.
  - y >= SCREEN_HEIGHT-1-BALL_RADIUS: y = that bound, dy = -1.
- PADHIT, left pad (right pad mirrored):
  - Condition: dx = -1, x <= PAD_DISTANCE+PAD_WIDTH+BALL_RADIUS (28), and |y - pad_left| < PAD_HEIGHT/2+BALL_RADIUS (36).
  - Action: x = 28, dx = +1. Uses post-PADS pad values.
  - Right-pad face: x >= SCREEN_WIDTH-1-28 = 611.
- SCORE:
  - Miss on the left: x <= BALL_RADIUS. Right score +1, ball recentred, launched = 0, dx = -1 (next serve goes toward the player who conceded).
  - Miss on the right: mirrored.
  - A score reaching WIN_SCORE sets game_over. game_over freezes all state until reset; pads stay frozen too.
  - Scores never exceed WIN_SCORE.
- Simultaneous events:
  - Wall and pad contact in one frame: both reflections apply.
  - Pad hit takes priority over miss in the same frame.
- Reset mid-update: returns to reset values immediately. The committed outputs are never partially updated.

Optional Feature:
- Macro: AI_PAD_EN.
- Defined: the right pad ignores btn[3:2]. In PADS it moves PAD_SPEED toward ball_y when |ball_y - pad_right| > PAD_SPEED, otherwise it holds. Clamping is unchanged.
- Undefined: the right pad is driven by btn[3:2] only. The module has no AI logic.

Test Plan:
- Reset, then 3 vga_vs falling edges with no buttons -> busy high for 6 cycles per edge. Outputs stay 240/240/320/240, scores 0.
- Hold btn[0] (l_up) for 60 frames -> pad_left steps 236, 232, ..., and clamps at 32. Pressing l_up and l_dn together -> no change.
- Pulse serve, then 2 frames -> ball_x = 324, ball_y = 244 at the second COMMIT. Output ball_x is unchanged between COMMITs.
- Ball y drifting to 474 with dy = +1 -> y clamped to 475, dy = -1. The next frame gives y = 473.
- Left pad at 240, ball arriving at x = 28 with y = 270 -> bounces, dx = +1. Same with y = 280 -> miss: score_right = 1, ball at 320/240, held until serve.
- Drive score_right to 9 -> game_over = 1. Further frames and serves leave all outputs frozen. A vga_vs edge during busy is ignored; asserting rst mid-FSM restores reset values.

Source files
------------

// File: rtl/game_state_sequencer.sv
// game_state_sequencer: per-frame pong logic for the graphics pipeline.
// Each vga_vs falling edge starts a fixed update sequence on working copies:
// PADS -> BALL -> WALLS -> PADHIT -> SCORE -> COMMIT. The outputs are loaded
// only on the COMMIT cycle, so the raster never sees a half-updated frame.
// Optional build macro AI_PAD_EN: the right pad follows the ball instead of btn[3:2].
module game_state_sequencer #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned PAD_HEIGHT    = 64,
  parameter int unsigned PAD_WIDTH     = 8,
  parameter int unsigned PAD_DISTANCE  = 16,
  parameter int unsigned PAD_SPEED     = 4,
  parameter int unsigned BALL_SPEED    = 2,
  parameter int unsigned BALL_RADIUS   = 4,
  parameter int unsigned WIN_SCORE     = 9
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        vga_vs,
  input  logic [3:0]  btn,
  input  logic        serve,
  output logic [11:0] pad_left,
  output logic [11:0] pad_right,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [3:0]  score_left,
  output logic [3:0]  score_right,
  output logic        game_over,
  output logic        busy
);

  localparam int unsigned CW   = 12;
  localparam int unsigned SW   = CW + 1;
  localparam int unsigned FACE = PAD_DISTANCE + PAD_WIDTH + BALL_RADIUS;

  typedef logic signed [SW-1:0] coord_t;

  localparam coord_t PAD_MIN  = SW'(PAD_HEIGHT / 2);
  localparam coord_t PAD_MAX  = SW'(SCREEN_HEIGHT - 1 - PAD_HEIGHT / 2);
  localparam coord_t CX       = SW'(SCREEN_WIDTH / 2);
  localparam coord_t CY       = SW'(SCREEN_HEIGHT / 2);
  localparam coord_t Y_MIN    = SW'(BALL_RADIUS);
  localparam coord_t Y_MAX    = SW'(SCREEN_HEIGHT - 1 - BALL_RADIUS);
  localparam coord_t FACE_L   = SW'(FACE);
  localparam coord_t FACE_R   = SW'(SCREEN_WIDTH - 1 - FACE);
  localparam coord_t MISS_L   = SW'(BALL_RADIUS);
  localparam coord_t MISS_R   = SW'(SCREEN_WIDTH - 1 - BALL_RADIUS);
  localparam coord_t HIT_SPAN = SW'(PAD_HEIGHT / 2 + BALL_RADIUS);
  localparam coord_t PSTEP    = SW'(PAD_SPEED);
  localparam coord_t BSTEP    = SW'(BALL_SPEED);
  localparam logic [3:0] WIN  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE, PADS, BALL, WALLS, PADHIT, SCORE, COMMIT} state_t;

  state_t     state, state_d;
  logic       vs_prev, frame_start;
  coord_t     wl, wr, wx, wy, wl_d, wr_d, wx_d, wy_d;
  logic       dx_neg, dy_neg, launched, over;
  logic       dx_neg_d, dy_neg_d, launched_d, over_d;
  logic [3:0] sl, sr, sl_d, sr_d;
  logic       commit;
  logic       right_up, right_dn;

  // Pad step with clamping; both or neither button means no move.
  function automatic coord_t pad_move(input coord_t y, input logic up, input logic dn);
    coord_t t;
    t = y;
    if (up && !dn)      t = y - PSTEP;
    else if (dn && !up) t = y + PSTEP;
    if (t < PAD_MIN)      t = PAD_MIN;
    else if (t > PAD_MAX) t = PAD_MAX;
    return t;
  endfunction

  // True when the ball centre is vertically within the pad's reach.
  function automatic logic pad_reach(input coord_t a, input coord_t b);
    coord_t d;
    d = a - b;
    if (d[SW-1]) d = -d;
    return d < HIT_SPAN;
  endfunction

  assign frame_start = vs_prev & ~vga_vs;

`ifdef AI_PAD_EN
  coord_t ai_diff;
  logic   unused_btn;
  assign ai_diff    = wy - wr;
  assign right_up   = ai_diff < -PSTEP;
  assign right_dn   = ai_diff > PSTEP;
  assign unused_btn = ^btn[3:2];
`else
  assign right_up = btn[2];
  assign right_dn = btn[3];
`endif

  // State register.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next state and working-copy updates, one update step per state.
  always_comb begin
    state_d    = state;
    wl_d       = wl;
    wr_d       = wr;
    wx_d       = wx;
    wy_d       = wy;
    dx_neg_d   = dx_neg;
    dy_neg_d   = dy_neg;
    launched_d = launched;
    over_d     = over;
    sl_d       = sl;
    sr_d       = sr;
    commit     = 1'b0;
    if (serve && !over) launched_d = 1'b1;
    case (state)
      IDLE: if (frame_start && !over) state_d = PADS;
      PADS: begin
        state_d = BALL;
        wl_d    = pad_move(wl, btn[0], btn[1]);
        wr_d    = pad_move(wr, right_up, right_dn);
      end
      BALL: begin
        state_d = WALLS;
        if (launched) begin
          wx_d = dx_neg ? wx - BSTEP : wx + BSTEP;
          wy_d = dy_neg ? wy - BSTEP : wy + BSTEP;
        end else begin
          wx_d = CX;
          wy_d = CY;
        end
      end
      WALLS: begin
        state_d = PADHIT;
        if (wy <= Y_MIN) begin
          wy_d     = Y_MIN;
          dy_neg_d = 1'b0;
        end else if (wy >= Y_MAX) begin
          wy_d     = Y_MAX;
          dy_neg_d = 1'b1;
        end
      end
      PADHIT: begin
        state_d = SCORE;
        if (dx_neg && wx <= FACE_L && pad_reach(wy, wl)) begin
          wx_d     = FACE_L;
          dx_neg_d = 1'b0;
        end else if (!dx_neg && wx >= FACE_R && pad_reach(wy, wr)) begin
          wx_d     = FACE_R;
          dx_neg_d = 1'b1;
        end
      end
      SCORE: begin
        state_d = COMMIT;
        if (wx <= MISS_L) begin
          if (sr < WIN) sr_d = sr + 4'd1;
          wx_d       = CX;
          wy_d       = CY;
          launched_d = 1'b0;
          dx_neg_d   = 1'b1;
        end else if (wx >= MISS_R) begin
          if (sl < WIN) sl_d = sl + 4'd1;
          wx_d       = CX;
          wy_d       = CY;
          launched_d = 1'b0;
          dx_neg_d   = 1'b0;
        end
        over_d = (sl_d == WIN) || (sr_d == WIN);
      end
      COMMIT: begin
        state_d = IDLE;
        commit  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working copies and frame-edge history.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      vs_prev  <= 1'b1;
      wl       <= CY;
      wr       <= CY;
      wx       <= CX;
      wy       <= CY;
      dx_neg   <= 1'b0;
      dy_neg   <= 1'b0;
      launched <= 1'b0;
      over     <= 1'b0;
      sl       <= 4'd0;
      sr       <= 4'd0;
    end else begin
      vs_prev  <= vga_vs;
      wl       <= wl_d;
      wr       <= wr_d;
      wx       <= wx_d;
      wy       <= wy_d;
      dx_neg   <= dx_neg_d;
      dy_neg   <= dy_neg_d;
      launched <= launched_d;
      over     <= over_d;
      sl       <= sl_d;
      sr       <= sr_d;
    end
  end

  // Published outputs: loaded together on COMMIT only.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      pad_left    <= CW'(CY);
      pad_right   <= CW'(CY);
      ball_x      <= CW'(CX);
      ball_y      <= CW'(CY);
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (commit) begin
        pad_left    <= CW'(wl);
        pad_right   <= CW'(wr);
        ball_x      <= CW'(wx);
        ball_y      <= CW'(wy);
        score_left  <= sl;
        score_right <= sr;
        game_over   <= over;
      end
    end
  end

endmodule
